lii_stream_packer: RTL
======================

Name: lii_stream_packer

Overview:
- Transmit-side LII adapter for a producer HLS kernel. Joins two independent logical AXI-Stream lanes into one packed LII phy output channel.
- Lane 0 is packed into bits [LW-1:0] and lane 1 into [2*LW-1:LW]. Each beat carries fixed src/dst tags.
- Each lane is decoupled by a one-entry holding slot, so the lanes need not be valid in the same cycle. The output is fully registered.
- Reports frame boundaries and drives the producer kernel's clock enable.

Parameters:
- LW, 256, width of each logical input lane
- PW, 512, LII packing width; must satisfy 2*LW <= PW
- SRC_ID, 8'h00, value driven on lii_out_p0_src
- DST_ID, 8'h01, value driven on lii_out_p0_dst
- FRAME_BEATS, 16, output beats per frame; must be >= 1

Ports:
- aclk  in  1  clock
- arst  in  1  asynchronous active-high reset
- lane0_tdata  in  LW  logical lane 0 data
- lane0_tvalid  in  1  lane 0 valid
- lane0_tready  out  1  lane 0 ready
- lane1_tdata  in  LW  logical lane 1 data
- lane1_tvalid  in  1  lane 1 valid
- lane1_tready  out  1  lane 1 ready
- lii_out_p0_tdata  out  PW  packed phy data
- lii_out_p0_tvalid  out  1  phy valid
- lii_out_p0_tready  in  1  phy ready
- lii_out_p0_src  out  8  source tag
- lii_out_p0_dst  out  8  destination tag
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted
- ce  out  1  producer kernel clock enable

Behaviour:
- One clock (aclk). Reset arst is asynchronous and active-high.
- Reset values:
  - both slot full flags = 0, lii_out_p0_tvalid = 0, lii_out_p0_tdata = 0
  - beat counter = 0, frame_done = 0
  - src/dst are constants SRC_ID/DST_ID at all times, including during reset
- Lane slot i holds full_i and data_i.
  - laneI_tready = !full_i | join.
  - Accept (valid & ready): data_i <= tdata, full_i <= 1.
  - join without accept: full_i <= 0. join with accept in the same cycle: full_i stays 1 and data is replaced (no bubble).
- out_free = !lii_out_p0_tvalid | lii_out_p0_tready.
- join = full_0 & full_1 & out_free.
  - On join: tdata <= {zero pad, data_1, data_0} and tvalid <= 1.
  - Else if tready: tvalid <= 0.
- Output tdata and tvalid hold stable while tvalid & !tready (AXI rule). Bits [PW-1:2*LW] are always 0.
- Latency: the later of the two lane handshakes at edge k gives tvalid high after edge k+1.
- Throughput: 1 beat/cycle sustained when both lanes are valid and tready is constantly 1.
- A lane arriving early waits in its slot indefinitely. Its tready is low while its slot is full and no join occurs. No timeout, no drop.
- Beat counter, width clog2(FRAME_BEATS) (min 1), advances on each output handshake.
  - At FRAME_BEATS-1 with a handshake: wraps to 0 and frame_done <= 1 for exactly the next cycle.
  - Otherwise frame_done <= 0.
  - FRAME_BEATS=1: frame_done pulses once per accepted beat.
- ce = lane0_tready & lane1_tready. This is combinational and stalls the kernel whenever either slot is blocked.
- Reset asserted mid-operation: held slot data and any un-handshaked output beat are discarded, the counter clears, and nothing is emitted afterwards until new data arrives.
- No X on outputs after reset. tvalid must never depend combinationally on tready.

Decomposition:
- Package lii_pkg:
  - LII_PW (512), LII_TAG_W (8), typedef lii_tag_t
  - function clog2_min1 for counter sizing
  - elaboration checks for 2*LW <= PW and FRAME_BEATS >= 1
- One sub-module, lii_lane_slot: a one-entry holding register with full flag and drain input. It is instantiated twice. The join, output register and counter live in the top.

Test Plan:
- Both lanes valid every cycle, tready=1, lane0 = i, lane1 = 100+i for i = 0..31 -> 32 beats, one per cycle, each tdata = {256'(100+i), 256'(i)}. First tvalid 2 cycles after the first accept. frame_done pulses after beats 15 and 31.
- Lane0 valid at cycle 0 with A; lane1 valid at cycle 5 with B -> lane0_tready low for cycles 1-5. A single beat {B,A} appears at cycle 7. ce low while lane0 is waiting.
- Output backpressure: tready=0 for 10 cycles with beat X pending and both slots refilled -> tdata stays X, both lane treadys stay 0, and ce = 0. On release: X is accepted, the next beat follows on the next cycle, and nothing is lost or duplicated.
- Random valid/ready on all three interfaces over 10k cycles -> scoreboard: output sequence equals the in-order pairwise zip of the lane inputs, and upper pad bits are always 0.
- arst pulsed while both slots are full and tvalid=1 -> tvalid=0 immediately (asynchronously), counter = 0. A subsequent fresh pair produces exactly one beat and frame counting restarts from 0.
- FRAME_BEATS=1 build -> frame_done pulses one cycle after every output handshake.

Source files
------------

// File: rtl/lii_pkg.sv
// Shared constants, types and helpers for the LII stream packer.
package lii_pkg;

  localparam int LII_PW    = 512;
  localparam int LII_TAG_W = 8;

  typedef logic [LII_TAG_W-1:0] lii_tag_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Parameter legality: both lanes must fit in the phy word and a frame needs at least one beat.
  function automatic bit params_ok(input int lw, input int pw, input int frameBeats);
    return (2 * lw <= pw) && (frameBeats >= 1);
  endfunction

endpackage

// File: rtl/lii_lane_slot.sv
// One-entry holding slot for a logical AXI-Stream lane; drained when the pair is joined.
module lii_lane_slot
  import lii_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tdata_i,
  input  logic         tvalid_i,
  output logic         tready_o,
  input  logic         drain_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  // Refill in the same cycle as a drain so back-to-back joins leave no bubble.
  always_comb begin
    tready_o = !full_q | drain_i;
    accept   = tvalid_i & tready_o;
    full_d   = full_q;
    data_d   = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = tdata_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  // Slot state register; reset empties the slot and discards held data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/lii_stream_packer.sv
// Joins two logical lanes into one registered, packed LII phy beat and tracks frame boundaries.
module lii_stream_packer
  import lii_pkg::*;
#(
  parameter int       LW          = 256,
  parameter int       PW          = LII_PW,
  parameter lii_tag_t SRC_ID      = 8'h00,
  parameter lii_tag_t DST_ID      = 8'h01,
  parameter int       FRAME_BEATS = 16
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [LW-1:0] lane0_tdata,
  input  logic          lane0_tvalid,
  output logic          lane0_tready,
  input  logic [LW-1:0] lane1_tdata,
  input  logic          lane1_tvalid,
  output logic          lane1_tready,
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  input  logic          lii_out_p0_tready,
  output lii_tag_t      lii_out_p0_src,
  output lii_tag_t      lii_out_p0_dst,
  output logic          frame_done,
  output logic          ce
);

  localparam int             CW        = clog2_min1(FRAME_BEATS);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(FRAME_BEATS - 1);

  if (!params_ok(LW, PW, FRAME_BEATS)) begin : gParamCheck
    $error("lii_stream_packer: need 2*LW <= PW and FRAME_BEATS >= 1");
  end

  logic          full0, full1;
  logic [LW-1:0] data0, data1;
  logic          outFree, pairJoin, outHs;

  logic [PW-1:0] outData_q, outData_d;
  logic          outValid_q, outValid_d;
  logic [CW-1:0] beatCnt_q, beatCnt_d;
  logic          frameDone_q, frameDone_d;

  lii_lane_slot #(.W(LW)) uSlot0 (
    .clk_i    (aclk),
    .rst_i    (arst),
    .tdata_i  (lane0_tdata),
    .tvalid_i (lane0_tvalid),
    .tready_o (lane0_tready),
    .drain_i  (pairJoin),
    .full_o   (full0),
    .data_o   (data0)
  );

  lii_lane_slot #(.W(LW)) uSlot1 (
    .clk_i    (aclk),
    .rst_i    (arst),
    .tdata_i  (lane1_tdata),
    .tvalid_i (lane1_tvalid),
    .tready_o (lane1_tready),
    .drain_i  (pairJoin),
    .full_o   (full1),
    .data_o   (data1)
  );

  // Join both slots into the output register when it is empty or being emptied; count accepted beats.
  always_comb begin
    outFree     = !outValid_q | lii_out_p0_tready;
    pairJoin    = full0 & full1 & outFree;
    outHs       = outValid_q & lii_out_p0_tready;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    beatCnt_d   = beatCnt_q;
    frameDone_d = 1'b0;
    if (pairJoin) begin
      outData_d             = '0;
      outData_d[2*LW-1:0]   = {data1, data0};
      outValid_d            = 1'b1;
    end else if (lii_out_p0_tready) begin
      outValid_d = 1'b0;
    end
    if (outHs) begin
      if (beatCnt_q == LAST_BEAT) begin
        beatCnt_d   = '0;
        frameDone_d = 1'b1;
      end else begin
        beatCnt_d = beatCnt_q + CW'(1);
      end
    end
  end

  // Output beat, beat counter and frame pulse registers; reset drops any pending beat.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      beatCnt_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      beatCnt_q   <= beatCnt_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign lii_out_p0_tdata  = outData_q;
  assign lii_out_p0_tvalid = outValid_q;
  assign lii_out_p0_src    = SRC_ID;
  assign lii_out_p0_dst    = DST_ID;
  assign frame_done        = frameDone_q;
  assign ce                = lane0_tready & lane1_tready;

endmodule
